// File: rtl/sopc_anemo_outputs_pulse_if.sv
// Avalon-MM slave bus bundle for the anemometer output PIO.
// readdata is always 32 bits wide; narrower registers are zero-extended.
interface sopc_anemo_outputs_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_anemo_outputs_pulse.sv
// Output PIO with direct write, atomic set/clear/toggle and per-bit hardware-timed pulses.
// out_port is the DATA register itself, so a write is visible one edge later.
module sopc_anemo_outputs_pulse #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      CNT_W         = 16,
    parameter int unsigned      PULSE_DEFAULT = 1000,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                            clk,
    input  logic                            reset,
    sopc_anemo_outputs_pulse_if.slave       bus,
    output logic [WIDTH-1:0]                out_port
);

    typedef enum logic [2:0] {
        REG_DATA   = 3'd0,
        REG_SET    = 3'd1,
        REG_CLEAR  = 3'd2,
        REG_TOGGLE = 3'd3,
        REG_PULSE  = 3'd4,
        REG_LEN    = 3'd5,
        REG_INFO   = 3'd6,
        REG_RSVD   = 3'd7
    } reg_addr_e;

    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_busy;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic [CNT_W-1:0] r_len;

    reg_addr_e        w_addr;
    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [CNT_W-1:0] w_len_wd;
    logic [CNT_W-1:0] w_load;
    logic             w_unused;

    assign w_addr   = reg_addr_e'(bus.address);
    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_wd     = bus.writedata[WIDTH-1:0];
    assign w_len_wd = bus.writedata[CNT_W-1:0];
    assign w_unused = ^bus.writedata;

    // A programmed length of 0 behaves as 1 so every pulse is at least one cycle wide.
    assign w_load = (r_len == '0) ? '0 : r_len - CNT_W'(1);

    assign out_port = r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VALUE;
            r_busy <= '0;
            r_len  <= CNT_W'(PULSE_DEFAULT);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            // Later assignments win, so CPU writes override the expiry/decrement path.
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (r_busy[i]) begin
                    if (r_cnt[i] == '0) begin
                        r_data[i] <= 1'b0;
                        r_busy[i] <= 1'b0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    end
                end
                if (w_wr) begin
                    case (w_addr)
                        REG_DATA: begin
                            r_data[i] <= w_wd[i];
                            r_busy[i] <= 1'b0;
                        end
                        REG_SET: if (w_wd[i]) begin
                            r_data[i] <= 1'b1;
                            r_busy[i] <= 1'b0;
                        end
                        REG_CLEAR: if (w_wd[i]) begin
                            r_data[i] <= 1'b0;
                            r_busy[i] <= 1'b0;
                        end
                        REG_TOGGLE: if (w_wd[i]) begin
                            r_data[i] <= ~r_data[i];
                            r_busy[i] <= 1'b0;
                        end
                        REG_PULSE: if (w_wd[i]) begin
                            r_data[i] <= 1'b1;
                            r_busy[i] <= 1'b1;
                            r_cnt[i]  <= w_load;
                        end
                        default: ;
                    endcase
                end
            end
            if (w_wr && w_addr == REG_LEN) begin
                r_len <= w_len_wd;
            end
        end
    end

    always_comb begin
        bus.readdata = '0;
        if (bus.chipselect) begin
            case (w_addr)
                REG_DATA:  bus.readdata[WIDTH-1:0] = r_data;
                REG_PULSE: bus.readdata[WIDTH-1:0] = r_busy;
                REG_LEN:   bus.readdata[CNT_W-1:0] = r_len;
                REG_INFO:  bus.readdata = {8'h00, 8'(CNT_W), 8'(WIDTH), 8'hA1};
                default:   bus.readdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sopc_anemo_outputs_pulse.sv
// Directed self-checking bench for sopc_anemo_outputs_pulse (WIDTH=8, CNT_W=16, RESET_VALUE=8'h5A).
module tb_sopc_anemo_outputs_pulse;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd1;
    localparam logic [2:0] A_CLEAR  = 3'd2;
    localparam logic [2:0] A_TOGGLE = 3'd3;
    localparam logic [2:0] A_PULSE  = 3'd4;
    localparam logic [2:0] A_LEN    = 3'd5;
    localparam logic [2:0] A_INFO   = 3'd6;
    localparam logic [2:0] A_RSVD   = 3'd7;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] out_port;
    int         n_tests = 0;
    int         n_fail  = 0;

    sopc_anemo_outputs_pulse_if bus();

    sopc_anemo_outputs_pulse #(
        .WIDTH(8),
        .CNT_W(16),
        .PULSE_DEFAULT(1000),
        .RESET_VALUE(8'h5A)
    ) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus),
        .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.write_n    = 1'b1;
        bus.chipselect = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        #12;
        n_tests++;
        if (out_port !== 8'h5A) begin n_fail++; $display("FAIL reset_out got %h want 5a", out_port); end
        bus_read(A_DATA, rd);
        n_tests++;
        if (rd !== 32'h5A) begin n_fail++; $display("FAIL reset_data got %h want 0000005a", rd); end
        bus_read(A_LEN, rd);
        n_tests++;
        if (rd !== 32'd1000) begin n_fail++; $display("FAIL reset_len got %0d want 1000", rd); end
        bus_read(A_PULSE, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_busy got %h want 0", rd); end
        bus_read(A_INFO, rd);
        n_tests++;
        if (rd !== 32'h001008A1) begin n_fail++; $display("FAIL info got %h want 001008a1", rd); end
        bus.address = A_DATA; bus.chipselect = 1'b0; #1;
        n_tests++;
        if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL rd_no_cs got %h want 0", bus.readdata); end
        @(negedge clk); rst = 1'b0;
        bus_write(A_DATA, 32'h0000_0000);
        n_tests++;
        if (out_port !== 8'h00) begin n_fail++; $display("FAIL write_after_reset got %h want 00", out_port); end
        // Mid-cycle reset: no clock edge between assertion and check.
        @(posedge clk); #3; rst = 1'b1; #1;
        n_tests++;
        if (out_port !== 8'h5A) begin n_fail++; $display("FAIL async_reset got %h want 5a", out_port); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_atomic();
        logic [31:0] rd;
        bus_write(A_DATA, 32'hABCD_EF0F);
        bus_read(A_DATA, rd);
        n_tests++;
        if (rd !== 32'h0F) begin n_fail++; $display("FAIL data_wr got %h want 0f", rd); end
        bus_write(A_SET, 32'h30);
        bus_read(A_DATA, rd);
        n_tests++;
        if (rd !== 32'h3F) begin n_fail++; $display("FAIL set got %h want 3f", rd); end
        bus_write(A_CLEAR, 32'h03);
        bus_read(A_DATA, rd);
        n_tests++;
        if (rd !== 32'h3C) begin n_fail++; $display("FAIL clear got %h want 3c", rd); end
        bus_write(A_TOGGLE, 32'h81);
        bus_read(A_DATA, rd);
        n_tests++;
        if (rd !== 32'hBD) begin n_fail++; $display("FAIL toggle got %h want bd", rd); end
        n_tests++;
        if (out_port !== 8'hBD) begin n_fail++; $display("FAIL toggle_out got %h want bd", out_port); end
        bus_read(A_SET, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL set_read got %h want 0", rd); end
        bus_read(A_CLEAR, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL clear_read got %h want 0", rd); end
        bus_read(A_TOGGLE, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL toggle_read got %h want 0", rd); end
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_read(A_RSVD, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL rsvd_read got %h want 0", rd); end
        n_tests++;
        if (out_port !== 8'hBD) begin n_fail++; $display("FAIL rsvd_write got %h want bd", out_port); end
        bus_write(A_LEN, 32'hFFFF_0005);
        bus_read(A_LEN, rd);
        n_tests++;
        if (rd !== 32'h5) begin n_fail++; $display("FAIL len_mask got %h want 5", rd); end
    endtask

    task automatic test_pulse_timing();
        logic [31:0] rd;
        bus_write(A_DATA, 32'h80);
        bus_write(A_LEN, 32'd5);
        bus_write(A_PULSE, 32'h01);
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (out_port !== 8'h81) begin n_fail++; $display("FAIL pulse_high[%0d] got %h want 81", k, out_port); end
            bus_read(A_PULSE, rd);
            n_tests++;
            if (rd !== 32'h1) begin n_fail++; $display("FAIL pulse_busy[%0d] got %h want 1", k, rd); end
            @(posedge clk); #1;
        end
        n_tests++;
        if (out_port !== 8'h80) begin n_fail++; $display("FAIL pulse_end got %h want 80", out_port); end
        bus_read(A_PULSE, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL pulse_idle got %h want 0", rd); end
        bus_write(A_PULSE, 32'h0000_0100);
        bus_write(A_PULSE, 32'h0);
        n_tests++;
        if (out_port !== 8'h80) begin n_fail++; $display("FAIL pulse_mask0 got %h want 80", out_port); end
        bus_read(A_PULSE, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL pulse_mask0_busy got %h want 0", rd); end
    endtask

    task automatic test_retrigger();
        logic [7:0] s;
        logic [2:0] s0;
        s = '0;
        bus_write(A_DATA, 32'h0);
        bus_write(A_LEN, 32'd4);
        bus_write(A_PULSE, 32'h04);
        s[0] = out_port[2];
        for (int k = 1; k < 3; k++) begin
            @(posedge clk); #1; s[k] = out_port[2];
        end
        bus_write(A_PULSE, 32'h04);
        s[3] = out_port[2];
        for (int k = 4; k < 8; k++) begin
            @(posedge clk); #1; s[k] = out_port[2];
        end
        n_tests++;
        if (s !== 8'b0111_1111) begin n_fail++; $display("FAIL retrigger got %b want 01111111", s); end
        bus_write(A_LEN, 32'd0);
        bus_write(A_PULSE, 32'h08);
        s0[0] = out_port[3];
        for (int k = 1; k < 3; k++) begin
            @(posedge clk); #1; s0[k] = out_port[3];
        end
        n_tests++;
        if (s0 !== 3'b001) begin n_fail++; $display("FAIL len0 got %b want 001", s0); end
    endtask

    task automatic test_cancel_priority();
        logic [31:0] rd;
        bus_write(A_DATA, 32'h0);
        bus_write(A_LEN, 32'd10);
        bus_write(A_PULSE, 32'h02);
        repeat (3) @(posedge clk);
        bus_write(A_CLEAR, 32'h02);
        n_tests++;
        if (out_port !== 8'h00) begin n_fail++; $display("FAIL cancel_out got %h want 00", out_port); end
        bus_read(A_PULSE, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL cancel_busy got %h want 0", rd); end
        repeat (8) @(posedge clk);
        #1;
        n_tests++;
        if (out_port !== 8'h00) begin n_fail++; $display("FAIL cancel_stay got %h want 00", out_port); end
        bus_write(A_PULSE, 32'h02);
        repeat (9) @(posedge clk);
        bus_write(A_SET, 32'h02);
        n_tests++;
        if (out_port !== 8'h02) begin n_fail++; $display("FAIL prio_out got %h want 02", out_port); end
        bus_read(A_PULSE, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL prio_busy got %h want 0", rd); end
        @(posedge clk); #1;
        n_tests++;
        if (out_port !== 8'h02) begin n_fail++; $display("FAIL prio_hold got %h want 02", out_port); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] rd;
        logic [3:0]  s;
        bus_write(A_DATA, 32'h0);
        bus_write(A_LEN, 32'd20);
        bus_write(A_PULSE, 32'h07);
        n_tests++;
        if (out_port !== 8'h07) begin n_fail++; $display("FAIL multi_pulse got %h want 07", out_port); end
        repeat (2) @(posedge clk);
        #3; rst = 1'b1; #1;
        n_tests++;
        if (out_port !== 8'h5A) begin n_fail++; $display("FAIL mid_reset_out got %h want 5a", out_port); end
        bus_read(A_PULSE, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL mid_reset_busy got %h want 0", rd); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (out_port !== 8'h5A) begin n_fail++; $display("FAIL post_reset got %h want 5a", out_port); end
        bus_write(A_LEN, 32'd3);
        bus_write(A_PULSE, 32'h01);
        s[0] = out_port[0];
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1; s[k] = out_port[0];
        end
        n_tests++;
        if (s !== 4'b0111) begin n_fail++; $display("FAIL post_reset_pulse got %b want 0111", s); end
        n_tests++;
        if (out_port !== 8'h5A) begin n_fail++; $display("FAIL post_reset_final got %h want 5a", out_port); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        test_reset();
        test_atomic();
        test_pulse_timing();
        test_retrigger();
        test_cancel_priority();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
